blur_window_fetch: RTL and testbench
====================================

// Module: blur_window_fetch
// PURPOSE
//  Upstream feeder for the blur stage.
//  - Walks a 16-pixel-wide anchor across a greyscale frame stored in byte-wide
//    memory, row by row from top to bottom.
//  - For each anchor it fetches a 20-pixel window: anchor_x-2 .. anchor_x+17, on
//    row anchor_y. Columns outside the frame are clamped to the edge pixel.
//  - It presents the window, with its anchor coordinates, to the blur controller
//    over a valid/ready handshake.
// PARAMETERS
//  IMG_WIDTH   640  frame width in pixels; must be a multiple of 16, >= 16
//  IMG_HEIGHT  480  frame height in rows, >= 1
//  ADDR_BITS   20   memory byte-address width
//  COORD_BITS  16   width of the anchor_x / anchor_y outputs
// PORTS
//  clk           in   1          system clock, all logic on rising edge
//  rst           in   1          synchronous, active-high reset
//  start         in   1          begin a frame; sampled only in IDLE
//  img_base      in   ADDR_BITS  byte address of pixel (0,0); latched on start
//  mem_rd_en     out  1          one-cycle read request
//  mem_addr      out  ADDR_BITS  read address, valid while mem_rd_en=1
//  mem_rd_data   in   8          read data, valid while mem_rd_valid=1
//  mem_rd_valid  in   1          read response; >=1 cycle after request
//  win_valid     out  1          window and anchor outputs are valid
//  win_ready     in   1          consumer accepts the window
//  win_pixels    out  160        pixel k (k=0..19) is in bits [8k+7:8k]
//  anchor_x      out  COORD_BITS column of the pixel in window slot 2
//  anchor_y      out  COORD_BITS row of the window
//  frame_done    out  1          one-cycle pulse after the last window is accepted
// BEHAVIOUR
//  Reset
//  - Any cycle with rst=1: state=IDLE and every output is 0.
//  - rst overrides every other input, including mid-fetch and mid-present.
//  States: IDLE, REQ, WAIT, PRESENT, DONE.
//  IDLE
//  - start=1: latch img_base, set x=0, y=0, k=0, row_base=img_base; go to REQ.
//  - start=0: stay in IDLE.
//  REQ
//  - mem_rd_en=1 for exactly this cycle, then go to WAIT.
//  - mem_addr = row_base + clamp(x-2+k). clamp(c) = 0 if c<0; IMG_WIDTH-1 if
//    c>=IMG_WIDTH; otherwise c.
//  - The clamp is computed as a signed value of COORD_BITS+1 bits. The address
//    sum wraps modulo 2^ADDR_BITS.
//  WAIT
//  - One read is outstanding; mem_rd_en=0.
//  - On mem_rd_valid, mem_rd_data is written to slot k.
//    - k=19: go to PRESENT.
//    - otherwise: k+1, go to REQ.
//  - No timeout; the block waits indefinitely.
//  - mem_rd_valid in any other state is ignored. This covers a late response
//    that arrives after reset.
//  - A window therefore takes 20 requests and at least 40 cycles.
//  PRESENT
//  - win_valid=1. win_pixels, anchor_x and anchor_y stay constant while
//    win_ready=0. No memory traffic.
//  - On win_valid & win_ready, in the same edge:
//    - x < IMG_WIDTH-16: x+=16.
//    - else, y < IMG_HEIGHT-1: x=0, y+=1, row_base+=IMG_WIDTH.
//    - else: go to DONE.
//    - In both advance cases, k=0 and go to REQ.
//  - win_valid is 0 in the cycle after the handshake.
//  DONE
//  - frame_done=1 for one cycle, then go to IDLE.
//  - start is ignored in DONE and is accepted again from IDLE.
//  Frame totals: (IMG_WIDTH/16)*IMG_HEIGHT windows, 20 reads per window.
//  No multiplier: the row address is built incrementally through row_base.
// TESTING (IMG_WIDTH=32, IMG_HEIGHT=2, img_base=0x100, mem[a]=a[7:0])
//  1. rst held 3 cycles mid-WAIT, then a mem_rd_valid one cycle later.
//     -> All outputs 0, response ignored, no win_valid.
//     -> Next start fetches from 0x100 again.
//  2. Window at anchor (0,0), single-cycle memory latency.
//     -> Slots 0,1 = 0x00 (clamped).
//     -> Slots 2..19 = 0x00..0x11.
//     -> win_valid at cycle 40 after start.
//  3. Window at anchor (16,0).
//     -> Slots 0..17 = 0x0E..0x1F.
//     -> Slots 18,19 = 0x1F (right-edge clamp).
//     -> No mem_addr beyond 0x11F.
//  4. win_ready low for 50 cycles at (16,0).
//     -> win_valid stays 1; win_pixels and anchor stay stable.
//     -> mem_rd_en stays 0 throughout.
//  5. Random mem_rd_valid latency of 1-7 cycles over the full frame.
//     -> Windows arrive in order (0,0) (16,0) (0,1) (16,1).
//     -> Row-1 addresses start at 0x11E (clamped 0x120).
//     -> 80 mem_rd_en pulses in total.
//  6. Final handshake at (16,1).
//     -> frame_done high for exactly one cycle, then IDLE.
//     -> A start pulse during DONE is ignored.

Source files
------------

// File: rtl/blur_window_fetch_if.sv
// Bundle of the control, memory-read and window-presentation signals of the
// blur window fetcher. The fetcher is the master; its environment is the slave.
interface blur_window_fetch_if #(
  parameter int ADDR_BITS  = 20,
  parameter int COORD_BITS = 16
);

  // Frame control
  logic                  start;
  logic [ADDR_BITS-1:0]  img_base;
  logic                  frame_done;

  // Byte-wide memory read port, one request in flight at a time
  logic                  mem_rd_en;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [7:0]            mem_rd_data;
  logic                  mem_rd_valid;

  // Window presented to the blur controller
  logic                  win_valid;
  logic                  win_ready;
  logic [159:0]          win_pixels;
  logic [COORD_BITS-1:0] anchor_x;
  logic [COORD_BITS-1:0] anchor_y;

  modport master (
    input  start,
    input  img_base,
    input  mem_rd_data,
    input  mem_rd_valid,
    input  win_ready,
    output mem_rd_en,
    output mem_addr,
    output win_valid,
    output win_pixels,
    output anchor_x,
    output anchor_y,
    output frame_done
  );

  modport slave (
    output start,
    output img_base,
    output mem_rd_data,
    output mem_rd_valid,
    output win_ready,
    input  mem_rd_en,
    input  mem_addr,
    input  win_valid,
    input  win_pixels,
    input  anchor_x,
    input  anchor_y,
    input  frame_done
  );

endinterface

// File: rtl/blur_window_fetch.sv
// Blur window fetcher: walks a 16-pixel anchor across a byte-per-pixel frame,
// reads a 20-pixel window (anchor_x-2 .. anchor_x+17) for every anchor with
// edge clamping, and hands each window to the blur controller over
// valid/ready. Row addresses are stepped by adding the frame width, so no
// multiplier is needed.
module blur_window_fetch #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_BITS  = 20,
  parameter int COORD_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  blur_window_fetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    PRESENT,
    DONE
  } state_t;

  localparam logic [4:0]             K_LAST     = 5'd19;
  localparam logic [COORD_BITS-1:0]  X_STEP     = COORD_BITS'(16);
  localparam logic [COORD_BITS-1:0]  X_LAST     = COORD_BITS'(IMG_WIDTH - 16);
  localparam logic [COORD_BITS-1:0]  Y_LAST     = COORD_BITS'(IMG_HEIGHT - 1);
  localparam logic [COORD_BITS-1:0]  COL_MAX    = COORD_BITS'(IMG_WIDTH - 1);
  localparam logic signed [COORD_BITS:0] WIDTH_S = (COORD_BITS+1)'(IMG_WIDTH);
  localparam logic signed [COORD_BITS:0] TWO_S   = (COORD_BITS+1)'(2);
  localparam logic [ADDR_BITS-1:0]   ROW_STRIDE = ADDR_BITS'(IMG_WIDTH);

  state_t                state_q, state_d;
  logic [COORD_BITS-1:0] x_q, x_d;
  logic [COORD_BITS-1:0] y_q, y_d;
  logic [4:0]            k_q, k_d;
  logic [ADDR_BITS-1:0]  rowBase_q, rowBase_d;
  logic [159:0]          pix_q, pix_d;

  logic signed [COORD_BITS:0] colS;
  logic [COORD_BITS-1:0]      colC;
  logic [ADDR_BITS-1:0]       addrSum;

  // Column of the current slot relative to the anchor, one bit wider so the
  // two columns left of x=0 come out negative instead of wrapping.
  assign colS = $signed({1'b0, x_q})
              + $signed({{(COORD_BITS-4){1'b0}}, k_q})
              - TWO_S;

  // Clamp the slot column onto the frame so off-edge slots repeat the edge pixel.
  always_comb begin
    colC = colS[COORD_BITS-1:0];
    if (colS < 0) begin
      colC = '0;
    end else if (colS >= WIDTH_S) begin
      colC = COL_MAX;
    end
  end

  // Byte address of the slot; wraps naturally at the address width.
  assign addrSum = rowBase_q + ADDR_BITS'(colC);

  // State and datapath registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      k_q       <= '0;
      rowBase_q <= '0;
      pix_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      k_q       <= k_d;
      rowBase_q <= rowBase_d;
      pix_q     <= pix_d;
    end
  end

  // Next-state logic: fetch 20 slots one read at a time, present the window,
  // then advance the anchor along the row and down the frame.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    k_d       = k_q;
    rowBase_d = rowBase_q;
    pix_d     = pix_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d       = '0;
          y_d       = '0;
          k_d       = '0;
          rowBase_d = bus.img_base;
          state_d   = REQ;
        end
      end

      REQ: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.mem_rd_valid) begin
          pix_d[{k_q, 3'b000} +: 8] = bus.mem_rd_data;
          if (k_q == K_LAST) begin
            state_d = PRESENT;
          end else begin
            k_d     = k_q + 5'd1;
            state_d = REQ;
          end
        end
      end

      PRESENT: begin
        if (bus.win_ready) begin
          k_d = '0;
          if (x_q < X_LAST) begin
            x_d     = x_q + X_STEP;
            state_d = REQ;
          end else if (y_q < Y_LAST) begin
            x_d       = '0;
            y_d       = y_q + COORD_BITS'(1);
            rowBase_d = rowBase_q + ROW_STRIDE;
            state_d   = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the registered state and are forced low whenever reset is
  // asserted, including the first reset cycle before the registers clear.
  assign bus.mem_rd_en  = !rst && (state_q == REQ);
  assign bus.mem_addr   = (!rst && (state_q == REQ)) ? addrSum : '0;
  assign bus.win_valid  = !rst && (state_q == PRESENT);
  assign bus.win_pixels = rst ? '0 : pix_q;
  assign bus.anchor_x   = rst ? '0 : x_q;
  assign bus.anchor_y   = rst ? '0 : y_q;
  assign bus.frame_done = !rst && (state_q == DONE);

endmodule

// File: tb/tb_blur_window_fetch.sv
// Directed bench for blur_window_fetch on a 32x2 frame at 0x100, with a
// memory whose byte at address a reads back a[7:0].
module tb_blur_window_fetch;

  localparam int W  = 32;
  localparam int H  = 2;
  localparam int AB = 20;
  localparam int CB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vecCount  = 0;
  int missCount = 0;

  bit respHold  = 1'b1;
  bit randLat   = 1'b0;
  int forceReq  = 0;
  int forceSeen = 0;
  int rdCount   = 0;
  logic [AB-1:0] addrQ[$];

  always #5 clk = ~clk;

  blur_window_fetch_if #(.ADDR_BITS(AB), .COORD_BITS(CB)) bus ();

  blur_window_fetch #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_BITS (AB),
    .COORD_BITS(CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Memory responder: answers each request after 1 (or 1..7 random) cycles,
  // logs every request, and can inject one stray response on demand.
  initial begin : responder
    int pendCnt;
    logic [AB-1:0] pendAddr;
    pendCnt = 0;
    pendAddr = '0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = 8'h00;
      if (forceSeen != forceReq) begin
        forceSeen = forceReq;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 8'hA5;
      end
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = pendAddr[7:0];
        end
      end
      if (bus.mem_rd_en) begin
        rdCount++;
        addrQ.push_back(bus.mem_addr);
        if (!respHold) begin
          pendCnt  = randLat ? int'($urandom_range(7, 1)) : 1;
          pendAddr = bus.mem_addr;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitWindow(input string tag, output int cycles);
    cycles = 0;
    while (bus.win_valid !== 1'b1 && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " win_valid"}, 160'(bus.win_valid), 160'(1));
  endtask

  task automatic acceptWindow(input string tag);
    bus.win_ready = 1'b1;
    @(negedge clk);
    bus.win_ready = 1'b0;
    checkOutput({tag, " valid drops"}, 160'(bus.win_valid), 160'(0));
  endtask

  task automatic checkWindowAt(input string tag, input int ax, input int ay,
                               input logic [159:0] pix);
    checkOutput({tag, " anchor_x"}, 160'(bus.anchor_x), 160'(ax));
    checkOutput({tag, " anchor_y"}, 160'(bus.anchor_y), 160'(ay));
    checkOutput({tag, " pixels"}, bus.win_pixels, pix);
  endtask

  // Pack 20 slots whose values run first, first+1, ... saturated to [lo,hi].
  function automatic logic [159:0] rampWin(input int first, input int lo, input int hi);
    logic [159:0] v;
    int p;
    v = '0;
    for (int k = 0; k < 20; k++) begin
      p = first + k;
      if (p < lo) p = lo;
      if (p > hi) p = hi;
      v[8*k +: 8] = 8'(p);
    end
    return v;
  endfunction

  // Directed sequence: reset, reset mid-fetch, one frame at fixed latency,
  // one frame at random latency, and the end-of-frame pulse.
  initial begin : stimulus
    int n;
    int idx;
    int idx1;
    int rd0;
    int bad;
    logic [AB-1:0] mx;
    logic [159:0] w16y0;

    bus.start     = 1'b0;
    bus.img_base  = 20'h00100;
    bus.win_ready = 1'b0;
    rst           = 1'b1;
    w16y0         = rampWin(14, 0, 31);

    repeat (2) @(negedge clk);
    checkOutput("reset ctl", 160'({bus.win_valid, bus.mem_rd_en, bus.frame_done}), 160'(0));
    checkOutput("reset addr/anchor", 160'({bus.mem_addr, bus.anchor_x, bus.anchor_y}), 160'(0));
    checkOutput("reset pixels", bus.win_pixels, 160'(0));
    rst = 1'b0;

    // Reset held three cycles while a read is outstanding, then a stray response
    applyStimulus();
    checkOutput("t1 first req", 160'({bus.mem_rd_en, bus.mem_addr}), 160'({1'b1, 20'h00100}));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("t1 rst cycle %0d", i),
                  160'({bus.win_valid, bus.mem_rd_en, bus.frame_done, bus.mem_addr,
                        bus.anchor_x, bus.anchor_y}), 160'(0));
      @(negedge clk);
    end
    rst = 1'b0;
    #2 forceReq++;
    rd0 = rdCount;
    bad = 0;
    repeat (45) begin
      @(negedge clk);
      if (bus.win_valid !== 1'b0) bad++;
    end
    checkOutput("t1 no win_valid", 160'(bad), 160'(0));
    checkOutput("t1 no reads", 160'(rdCount - rd0), 160'(0));
    checkOutput("t1 stray ignored", bus.win_pixels, 160'(0));
    respHold = 1'b0;

    // First window, single-cycle memory
    idx = addrQ.size();
    rd0 = rdCount;
    applyStimulus();
    waitWindow("t2", n);
    checkOutput("t2 latency", 160'(n), 160'(40));
    checkWindowAt("t2", 0, 0, rampWin(-2, 0, 31));
    checkOutput("t2 first addr", 160'(addrQ[idx]), 160'(20'h00100));
    checkOutput("t2 reads", 160'(rdCount - rd0), 160'(20));

    // Second window, right-edge clamp
    idx = addrQ.size();
    acceptWindow("t2");
    waitWindow("t3", n);
    checkWindowAt("t3", 16, 0, w16y0);
    checkOutput("t3 first addr", 160'(addrQ[idx]), 160'(20'h0010E));
    mx = '0;
    for (int i = idx; i < addrQ.size(); i++) begin
      if (addrQ[i] > mx) mx = addrQ[i];
    end
    checkOutput("t3 max addr", 160'(mx), 160'(20'h0011F));

    // Consumer stalls for 50 cycles
    rd0 = rdCount;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.win_valid !== 1'b1 || bus.win_pixels !== w16y0 ||
          bus.anchor_x !== 16'd16 || bus.anchor_y !== 16'd0) bad++;
    end
    checkOutput("t4 stable", 160'(bad), 160'(0));
    checkOutput("t4 no reads", 160'(rdCount - rd0), 160'(0));
    acceptWindow("t4");

    // Remaining row of the first frame
    waitWindow("a row1 x0", n);
    checkWindowAt("a row1 x0", 0, 1, rampWin(30, 32, 63));
    acceptWindow("a row1 x0");
    waitWindow("a row1 x16", n);
    checkWindowAt("a row1 x16", 16, 1, rampWin(46, 32, 63));
    acceptWindow("a last");
    checkOutput("a frame_done", 160'(bus.frame_done), 160'(1));
    @(negedge clk);
    checkOutput("a frame_done pulse", 160'(bus.frame_done), 160'(0));

    // Full frame with random 1..7 cycle memory latency
    randLat = 1'b1;
    rd0 = rdCount;
    applyStimulus();
    waitWindow("b0", n);
    checkWindowAt("b0", 0, 0, rampWin(-2, 0, 31));
    acceptWindow("b0");
    waitWindow("b1", n);
    checkWindowAt("b1", 16, 0, w16y0);
    idx1 = addrQ.size();
    acceptWindow("b1");
    waitWindow("b2", n);
    checkWindowAt("b2", 0, 1, rampWin(30, 32, 63));
    checkOutput("t5 row1 first addr", 160'(addrQ[idx1]), 160'(20'h00120));
    acceptWindow("b2");
    waitWindow("b3", n);
    checkWindowAt("b3", 16, 1, rampWin(46, 32, 63));

    // Final handshake, frame_done pulse and start ignored in DONE
    acceptWindow("b3");
    checkOutput("t5 reads", 160'(rdCount - rd0), 160'(80));
    checkOutput("t6 frame_done", 160'(bus.frame_done), 160'(1));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("t6 one cycle", 160'(bus.frame_done), 160'(0));
    rd0 = rdCount;
    bad = 0;
    repeat (45) begin
      @(negedge clk);
      if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) bad++;
    end
    checkOutput("t6 idle", 160'(bad), 160'(0));
    checkOutput("t6 start ignored", 160'(rdCount - rd0), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
